// File: rtl/seq_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_alu_pkg                                                     |
// | Purpose  : Shared ALUOP encodings and FSM state type for the sequential    |
// |            ALU (seq_alu) and its multiplier (seq_alu_mul).                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_alu_mul                                                     |
// | Purpose  : Unsigned shift-add multiplier, one partial product per cycle.   |
// |            Only instantiated by seq_alu when SEQ_ALU_MUL_EN is defined.    |
// | Ports    : clk, rst_n (async, active-low), start (load a/b and begin),     |
// |            a, b (operands), busy (iterating), done (result final this      |
// |            cycle), result (2*TERMINAL_RANGE-bit product).                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_alu_mul #(
  parameter int TERMINAL_RANGE = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [TERMINAL_RANGE-1:0]     a,
  input  logic [TERMINAL_RANGE-1:0]     b,
  output logic                          busy,
  output logic                          done,
  output logic [2*TERMINAL_RANGE-1:0]   result
);

  localparam int                 c_cnt_w = $clog2(TERMINAL_RANGE + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TERMINAL_RANGE);

  logic                          r_busy;
  logic [c_cnt_w-1:0]            r_cnt;
  logic [2*TERMINAL_RANGE-1:0]   r_acc;
  logic [2*TERMINAL_RANGE-1:0]   r_mcand;
  logic [TERMINAL_RANGE-1:0]     r_mplier;

  // The first partial product (bit 0 of b) is folded into the start cycle so
  // the full product is settled after TERMINAL_RANGE busy cycles and the
  // parent can capture it on the edge that leaves BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= c_cnt_w'(1);
      r_acc    <= b[0] ? {{TERMINAL_RANGE{1'b0}}, a} : '0;
      r_mcand  <= {{(TERMINAL_RANGE-1){1'b0}}, a, 1'b0};
      r_mplier <= b >> 1;
    end else if (r_busy) begin
      if (r_cnt == c_last) begin
        r_busy <= 1'b0;
      end else begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_busy && (r_cnt == c_last);
  assign result = r_acc;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_alu                                                         |
// | Purpose  : Handshaked sequential ALU: ADD/SUB/AND/OR/XOR complete in one   |
// |            cycle, MUL (optional) via shift-add sub-module. Result and      |
// |            flags are registered and held until out_ready.                  |
// | Ports    : clk, rst_n (async, active-low); in_valid/in_ready request side; |
// |            A, B, cin, ALUOP operands; out_valid/out_ready result side;     |
// |            product, product_hi, cout, Zero, Neg, Ovf, Err results.         |
// | Config   : `define SEQ_ALU_MUL_EN to build the multiplier; otherwise       |
// |            ALUOP 101 is reported as an illegal op.                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int TERMINAL_RANGE = 8,
  parameter int OUT_REG        = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TERMINAL_RANGE-1:0] A,
  input  logic [TERMINAL_RANGE-1:0] B,
  input  logic                      cin,
  input  logic [2:0]                ALUOP,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TERMINAL_RANGE-1:0] product,
  output logic [TERMINAL_RANGE-1:0] product_hi,
  output logic                      cout,
  output logic                      Zero,
  output logic                      Neg,
  output logic                      Ovf,
  output logic                      Err
);

  localparam int c_msb = TERMINAL_RANGE - 1;

  // Only the fully registered output mode exists.
  if (TERMINAL_RANGE < 2 || TERMINAL_RANGE > 32 || OUT_REG != 1) begin : g_param_check
    $error("seq_alu: unsupported TERMINAL_RANGE or OUT_REG value");
  end

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_accept;
  logic [TERMINAL_RANGE:0]   w_sum;
  logic [TERMINAL_RANGE:0]   w_diff;
  logic [TERMINAL_RANGE-1:0] w_lo;
  logic                      w_cout;
  logic                      w_ovf;
  logic                      w_err;
  logic                      w_is_mul;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign w_accept  = in_valid && in_ready;

  // Extra top bit carries the carry-out (ADD) or borrow (SUB).
  assign w_sum  = {1'b0, A} + {1'b0, B} + (TERMINAL_RANGE+1)'(cin);
  assign w_diff = {1'b0, A} - {1'b0, B} - (TERMINAL_RANGE+1)'(cin);

  always_comb begin
    w_lo     = '0;
    w_cout   = 1'b0;
    w_ovf    = 1'b0;
    w_err    = 1'b0;
    w_is_mul = 1'b0;
    case (ALUOP)
      OP_ADD: begin
        w_lo   = w_sum[c_msb:0];
        w_cout = w_sum[TERMINAL_RANGE];
        w_ovf  = (A[c_msb] == B[c_msb]) && (w_sum[c_msb] != A[c_msb]);
      end
      OP_SUB: begin
        w_lo   = w_diff[c_msb:0];
        w_cout = ~w_diff[TERMINAL_RANGE];
        w_ovf  = (A[c_msb] != B[c_msb]) && (w_diff[c_msb] != A[c_msb]);
      end
      OP_AND: w_lo = A & B;
      OP_OR:  w_lo = A | B;
      OP_XOR: w_lo = A ^ B;
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: w_is_mul = 1'b1;
`endif
      default: w_err = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic                          w_mul_busy;
  logic                          w_mul_done;
  logic [2*TERMINAL_RANGE-1:0]   w_mul_res;

  seq_alu_mul #(
    .TERMINAL_RANGE (TERMINAL_RANGE)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_accept && w_is_mul),
    .a      (A),
    .b      (B),
    .busy   (w_mul_busy),
    .done   (w_mul_done),
    .result (w_mul_res)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_is_mul ? BUSY : HOLD;
        end
      end
      BUSY: begin
`ifdef SEQ_ALU_MUL_EN
        // A multiplier that has gone idle without signalling done cannot
        // occur in normal operation; leaving BUSY avoids a lock-up.
        if (w_mul_done || !w_mul_busy) begin
          w_state_nxt = HOLD;
        end
`else
        w_state_nxt = HOLD;
`endif
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Illegal ops yield w_lo = 0, which produces Zero = 1 and Neg = 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product    <= '0;
      product_hi <= '0;
      cout       <= 1'b0;
      Zero       <= 1'b0;
      Neg        <= 1'b0;
      Ovf        <= 1'b0;
      Err        <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      product    <= w_lo;
      product_hi <= '0;
      cout       <= w_cout;
      Zero       <= (w_lo == '0);
      Neg        <= w_lo[c_msb];
      Ovf        <= w_ovf;
      Err        <= w_err;
`ifdef SEQ_ALU_MUL_EN
    end else if ((r_state == BUSY) && w_mul_done) begin
      product    <= w_mul_res[c_msb:0];
      product_hi <= w_mul_res[2*TERMINAL_RANGE-1:TERMINAL_RANGE];
      cout       <= (w_mul_res[2*TERMINAL_RANGE-1:TERMINAL_RANGE] != '0);
      Zero       <= (w_mul_res[c_msb:0] == '0);
      Neg        <= w_mul_res[c_msb];
      Ovf        <= 1'b0;
      Err        <= 1'b0;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_alu                                                      |
// | Purpose  : Self-checking bench for seq_alu (TERMINAL_RANGE = 4): directed  |
// |            vectors, back-pressure, mid-operation reset and random ops      |
// |            compared against an arithmetic reference model.                 |
// | Config   : honours SEQ_ALU_MUL_EN the same way as the design.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_alu;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] A         = '0;
  logic [W-1:0] B         = '0;
  logic         cin       = 1'b0;
  logic [2:0]   ALUOP     = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] product;
  logic [W-1:0] product_hi;
  logic         cout, Zero, Neg, Ovf, Err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(
    .TERMINAL_RANGE (W),
    .OUT_REG        (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .cin        (cin),
    .ALUOP      (ALUOP),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .product_hi (product_hi),
    .cout       (cout),
    .Zero       (Zero),
    .Neg        (Neg),
    .Ovf        (Ovf),
    .Err        (Err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  // flags = {cout, Zero, Neg, Ovf, Err}
  function automatic void model(input int a, input int b, input int c, input int op,
                                output int hi, output int lo, output int flags,
                                output int lat);
    int sa, sb, t, cy, ov, er;
    hi = 0; lo = 0; lat = 1; cy = 0; ov = 0; er = 0;
    sa = (a >= M/2) ? a - M : a;
    sb = (b >= M/2) ? b - M : b;
    case (op)
      0: begin
        t  = a + b + c;
        lo = t % M;
        cy = (t >= M) ? 1 : 0;
        t  = sa + sb + c;
        ov = (t > M/2 - 1 || t < -M/2) ? 1 : 0;
      end
      1: begin
        t  = a - b - c;
        lo = (t + M) % M;
        cy = (a >= b + c) ? 1 : 0;
        t  = sa - sb - c;
        ov = (t > M/2 - 1 || t < -M/2) ? 1 : 0;
      end
      2: lo = a & b;
      3: lo = a | b;
      4: lo = a ^ b;
`ifdef SEQ_ALU_MUL_EN
      5: begin
        t   = a * b;
        lo  = t % M;
        hi  = t / M;
        cy  = (hi != 0) ? 1 : 0;
        lat = W + 1;
      end
`endif
      default: er = 1;
    endcase
    flags = (cy << 4) | ((lo == 0 ? 1 : 0) << 3) | ((lo >= M/2 ? 1 : 0) << 2) | (ov << 1) | er;
  endfunction

  // Issue one op, check latency and result, optionally stall out_ready for
  // 'hold' cycles, then check the handoff.
  task automatic run_op(input int a, input int b, input int c, input int op, input int hold);
    int hi, lo, fl, lat, n;
    model(a, b, c, op, hi, lo, fl, lat);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    A         = W'(a);
    B         = W'(b);
    cin       = c[0];
    ALUOP     = op[2:0];
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid = 1'b0;
      A        = W'($urandom);
      B        = W'($urandom);
      cin      = 1'($urandom);
      ALUOP    = 3'($urandom);
    end while (!out_valid && n < 64);
    check("latency", 32'(n), 32'(lat));
    check("data", 32'({product_hi, product}), 32'(hi * M + lo));
    check("flags", 32'({cout, Zero, Neg, Ovf, Err}), 32'(fl));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_handshake", 32'({out_valid, in_ready}), 32'b10);
      check("hold_stable", 32'({product_hi, product, cout, Zero, Neg, Ovf, Err}),
            32'((hi * M + lo) * 32 + fl));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("handoff", 32'({out_valid, in_ready}), 32'b01);
  endtask

  // Reset two cycles into an op (MUL when built, else an illegal op held by
  // back-pressure), then confirm a clean ADD afterwards.
  task automatic reset_mid_op();
    A         = 4'b1111;
    B         = 4'b1101;
    cin       = 1'b0;
    ALUOP     = 3'b101;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'({out_valid, in_ready, product_hi, product, cout, Zero, Neg, Ovf, Err}),
          32'h2000);
    @(posedge clk);
    @(negedge clk);
    check("reset_held", 32'({out_valid, in_ready, product_hi, product, cout, Zero, Neg, Ovf, Err}),
          32'h2000);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    run_op(3, 1, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op, hold;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({out_valid, in_ready, product_hi, product, cout, Zero, Neg, Ovf, Err}),
          32'h2000);
    rst_n = 1'b1;

    run_op(13, 4, 0, 0, 0);
    run_op(14, 1, 1, 0, 0);
    run_op(14, 14, 0, 1, 0);
    run_op(14, 6, 0, 1, 0);
    run_op(2, 3, 0, 1, 0);
    run_op(15, 13, 0, 5, 0);
    run_op(15, 15, 1, 0, 0);
    run_op(0, 15, 1, 1, 0);
    run_op(7, 1, 0, 0, 0);
    run_op(8, 1, 0, 1, 0);
    run_op(12, 10, 0, 2, 0);
    run_op(12, 10, 0, 3, 0);
    run_op(12, 10, 0, 4, 0);
    run_op(5, 9, 0, 6, 0);
    run_op(5, 9, 0, 0, 3);
    reset_mid_op();

    for (int k = 0; k < 80; k++) begin
      op   = int'($urandom_range(0, 7));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, 1)), op, hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter TERMINAL_RANGE, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have parameter OUT_REG, default 1, 1 = result/flags registered, 0 = single-cycle ops also registered (no combinational bypass; reserved, must be 1).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand/op request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 A, B  input  TERMINAL_RANGE each  operands.
REQ-008 cin  input  1  carry-in (ADD) / borrow-in (SUB).
REQ-009 ALUOP  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110/111 illegal.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 product  output  TERMINAL_RANGE  result low word.
REQ-013 product_hi  output  TERMINAL_RANGE  MUL high word; 0 for other ops.
REQ-014 cout, Zero, Neg, Ovf, Err  output  1 each  carry/no-borrow, product==0, product MSB, signed overflow (ADD/SUB only, else 0), illegal op.

Function
REQ-015 Request accepted on edge where in_valid && in_ready; operands, cin, ALUOP captured.
REQ-016 FSM states IDLE, BUSY, HOLD; in_ready = 1 only in IDLE.
REQ-017 ADD: {cout,product} = A + B + cin.
REQ-018 SUB: product = A - B - cin mod 2^TERMINAL_RANGE; cout = 1 when no borrow (A >= B + cin).
REQ-019 AND/OR/XOR: bitwise; cout = 0.
REQ-020 Non-MUL ops: IDLE -> HOLD on accept; out_valid asserted the cycle after accept (latency 1).
REQ-021 MUL: unsigned shift-add, IDLE -> BUSY on accept, exactly TERMINAL_RANGE cycles in BUSY, then HOLD; out_valid latency TERMINAL_RANGE + 1; {product_hi,product} = A*B; cout = (product_hi != 0).
REQ-022 Illegal op: latency 1, product = product_hi = 0, Err = 1, Zero = 1, other flags 0.
REQ-023 HOLD: outputs stable while out_valid && !out_ready; on out_ready, -> IDLE, out_valid deasserts next cycle.
REQ-024 Back-to-back: new request not accepted in the same cycle as result handoff; minimum 2-cycle issue interval.
REQ-025 Inputs A, B, cin, ALUOP ignored outside the accept edge; changes during BUSY do not affect result.
REQ-026 Zero and Neg evaluated on product (low word) only.

Reset
REQ-027 rst_n low at any time (including mid-MUL) SHALL immediately force IDLE, in_ready = 1, out_valid = 0, product = product_hi = 0, all flags 0; partial MUL discarded.
REQ-028 First accept possible on the first rising edge with rst_n high.

Configuration
REQ-029 Macro SEQ_ALU_MUL_EN defined: MUL implemented per REQ-021.
REQ-030 Macro SEQ_ALU_MUL_EN undefined: no multiplier logic, BUSY state unreachable, ALUOP 101 treated as illegal per REQ-022.

Structure
REQ-031 Package seq_alu_pkg SHALL hold ALUOP encodings (OP_ADD..OP_MUL) and FSM state typedef.
REQ-032 Multiplier SHALL be sub-module seq_alu_mul (start, busy, done, TERMINAL_RANGE-parametrised), instantiated only under SEQ_ALU_MUL_EN.
REQ-033 Flag generation and ADD/SUB/logic datapath SHALL reside in seq_alu.

Verification (TERMINAL_RANGE = 4, out_ready = 1 unless stated)
REQ-034 ADD A=1101 B=0100 cin=0 -> 1 cycle later product=0001, cout=1, Zero=0, Ovf=0.
REQ-035 ADD A=1110 B=0001 cin=1 -> product=0000, cout=1, Zero=1; SUB A=1110 B=1110 cin=0 -> product=0000, cout=1, Zero=1.
REQ-036 SUB A=1110 B=0110 cin=0 -> product=1000, cout=1, Neg=1, Ovf=0; SUB A=0010 B=0011 -> product=1111, cout=0.
REQ-037 MUL A=1111 B=1101 (macro on) -> out_valid after 5 cycles, product_hi=1100, product=0011, cout=1; macro off -> latency 1, Err=1, product=0.
REQ-038 Hold out_ready=0 for 3 cycles after ADD result -> product/flags stable, in_ready=0; release -> out_valid drops next cycle, in_ready=1.
REQ-039 Assert rst_n low 2 cycles into MUL -> all outputs 0, in_ready=1 asynchronously; subsequent ADD 0011+0001 -> product=0100.
